// File: rtl/ramp_capture.sv
// Single-slope ADC ramp controller with first-edge per-pixel code capture and valid/ready readout.
// Optional build macro RAMP_GRAY_EN: ramp_count port carries the Gray code of the binary counter.
module ramp_capture #(
    parameter int NUM_PIXELS  = 1,
    parameter int COUNT_WIDTH = 8,
    parameter int RAMP_STEPS  = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_PIXELS-1:0]             enable,
    output logic [COUNT_WIDTH-1:0]            ramp_count,
    output logic                              ramp_active,
    output logic                              busy,
    output logic [NUM_PIXELS*COUNT_WIDTH-1:0] data,
    output logic [NUM_PIXELS-1:0]             captured,
    output logic                              valid,
    input  logic                              ready,
    output logic [1:0]                        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] STEPS = COUNT_WIDTH'(RAMP_STEPS);

    state_t                              state_q, state_n;
    logic [COUNT_WIDTH-1:0]              cnt_q, cnt_n;
    logic [NUM_PIXELS*COUNT_WIDTH-1:0]   data_q, data_n;
    logic [NUM_PIXELS-1:0]               cap_q, cap_n;

    // Readout handshake: valid is high for the whole HOLD state and the codes are
    // transferred on any cycle where valid && ready; valid never drops without ready.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        cap_n   = cap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RAMP;
                    cnt_n   = '0;
                    data_n  = '0;
                    cap_n   = '0;
                end
            end
            RAMP: begin
                for (int i = 0; i < NUM_PIXELS; i++) begin
                    if (enable[i] && !cap_q[i]) begin
                        data_n[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
                        cap_n[i] = 1'b1;
                    end
                end
                if (cnt_q == STEPS) begin
                    state_n = HOLD;
                    // Pixels that never fired report the saturated code.
                    for (int i = 0; i < NUM_PIXELS; i++) begin
                        if (!cap_n[i]) begin
                            data_n[i*COUNT_WIDTH +: COUNT_WIDTH] = STEPS;
                        end
                    end
                end else begin
                    cnt_n = cnt_q + COUNT_WIDTH'(1);
                end
            end
            HOLD: begin
                if (ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            cap_q   <= cap_n;
        end
    end

`ifdef RAMP_GRAY_EN
    // Gray register is loaded from the next binary count so it lines up with cnt_q.
    logic [COUNT_WIDTH-1:0] gray_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= cnt_n ^ (cnt_n >> 1);
        end
    end

    assign ramp_count = gray_q;
`else
    assign ramp_count = cnt_q;
`endif

    assign ramp_active = (state_q == RAMP);
    assign busy        = (state_q != IDLE);
    assign valid       = (state_q == HOLD);
    assign data        = data_q;
    assign captured    = cap_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ramp_capture.sv
// Self-checking bench for ramp_capture: conversion-level reference model, expected-code queue,
// directed scenarios with literal expectations, and randomized conversions.
module tb_ramp_capture;

    localparam int NP    = 2;
    localparam int CW    = 8;
    localparam int STEPS = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NP-1:0]    enable;
    logic             ready;
    logic [CW-1:0]    ramp_count;
    logic             ramp_active;
    logic             busy;
    logic [NP*CW-1:0] data;
    logic [NP-1:0]    captured;
    logic             valid;
    logic [1:0]       state_dbg;

    ramp_capture #(
        .NUM_PIXELS (NP),
        .COUNT_WIDTH(CW),
        .RAMP_STEPS (STEPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .ramp_count (ramp_count),
        .ramp_active(ramp_active),
        .busy       (busy),
        .data       (data),
        .captured   (captured),
        .valid      (valid),
        .ready      (ready),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    int valid_rise_edge = 0;
    int valid_cycles = 0;
    logic prev_valid = 1'b0;

    logic [NP-1:0]       pulse_tab [0:STEPS];
    logic [NP*CW+NP-1:0] exp_q[$];

    // Reference model: one conversion is "active" from accepted start to the handshake;
    // age counts ramp cycles elapsed, age > STEPS means codes are waiting for readout.
    bit            m_active = 1'b0;
    int            m_age = 0;
    logic [CW-1:0] m_code [NP];
    logic [NP-1:0] m_cap = '0;
    logic [CW-1:0] m_idle_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [NP*CW-1:0] model_data();
        logic [NP*CW-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) r[p*CW +: CW] = m_code[p];
        return r;
    endfunction

    initial begin
        for (int p = 0; p < NP; p++) m_code[p] = '0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (reset) begin
                m_active     = 1'b0;
                m_cap        = '0;
                m_idle_count = '0;
                for (int p = 0; p < NP; p++) m_code[p] = '0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_age    = 0;
                    m_cap    = '0;
                    for (int p = 0; p < NP; p++) m_code[p] = '0;
                end
            end else if (m_age <= STEPS) begin
                for (int p = 0; p < NP; p++) begin
                    if (enable[p] && !m_cap[p]) begin
                        m_code[p] = CW'(m_age);
                        m_cap[p]  = 1'b1;
                    end
                end
                if (m_age == STEPS) begin
                    for (int p = 0; p < NP; p++) if (!m_cap[p]) m_code[p] = CW'(STEPS);
                    exp_q.push_back({m_cap, model_data()});
                end
                m_age++;
            end else if (ready) begin
                m_active     = 1'b0;
                m_idle_count = CW'(STEPS);
            end
        end
    end

    // Compare process: every cycle, mid-period
    initial begin
        logic [CW-1:0]       exp_cnt;
        logic [CW-1:0]       exp_rc;
        logic [NP*CW+NP-1:0] exp_word;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!m_active)           exp_cnt = m_idle_count;
            else if (m_age <= STEPS) exp_cnt = CW'(m_age);
            else                     exp_cnt = CW'(STEPS);
`ifdef RAMP_GRAY_EN
            exp_rc = exp_cnt ^ (exp_cnt >> 1);
`else
            exp_rc = exp_cnt;
`endif
            check("ramp_count", ramp_count, exp_rc);
            check("ramp_active", ramp_active, m_active && (m_age <= STEPS));
            check("busy", busy, m_active);
            check("valid", valid, m_active && (m_age > STEPS));
            check("data", data, model_data());
            check("captured", captured, m_cap);
            check("state_dbg_busy", state_dbg != 2'd0, m_active);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_readout", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("sb_readout", {captured, data}, exp_word);
                end
            end
            if (valid && !prev_valid) valid_rise_edge = edge_cnt;
            if (valid) valid_cycles++;
            prev_valid = valid;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tab();
        for (int c = 0; c <= STEPS; c++) pulse_tab[c] = '0;
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            start  = 1'b0;
            enable = NP'($urandom_range(0, 3));
            tick();
        end
        enable = '0;
    endtask

    task automatic run_conv(input int reset_at, input int hold_wait, input bit noise);
        start        = 1'b1;
        start_edge   = edge_cnt + 1;
        valid_cycles = 0;
        tick();
        start = 1'b0;
        for (int c = 0; c <= STEPS; c++) begin
            enable = pulse_tab[c];
            if (noise) start = 1'($urandom_range(0, 1));
            if (c == reset_at) begin
                reset = 1'b1;
                tick();
                reset  = 1'b0;
                enable = '0;
                start  = 1'b0;
                return;
            end
`ifdef RAMP_GRAY_EN
            if (c == STEPS) check("final_count_lit", ramp_count, 8'h80);
`else
            if (c == STEPS) check("final_count_lit", ramp_count, 8'hFF);
`endif
            tick();
        end
        enable = '0;
        for (int h = 0; h < hold_wait; h++) begin
            start  = 1'($urandom_range(0, 1));
            enable = NP'($urandom_range(0, 3));
            tick();
        end
        start  = 1'b0;
        enable = '0;
        ready  = 1'b1;
        tick();
        ready = 1'b0;
        check("valid_rise_latency", valid_rise_edge - start_edge, 256);
        check("valid_cycles", valid_cycles, hold_wait + 1);
        check("idle_after_ready", busy, 0);
    endtask

    initial begin
        int n;
        int idx;
        reset  = 1'b1;
        start  = 1'b0;
        enable = '0;
        ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_count", ramp_count, 0);
        check("reset_data", data, 0);
        check("reset_flags", {valid, busy, ramp_active, captured}, 0);

        // Basic capture
        clear_tab();
        pulse_tab[37][0]  = 1'b1;
        pulse_tab[200][1] = 1'b1;
        run_conv(-1, 0, 1'b0);
        check("basic_data", data, 16'hC825);
        check("basic_cap", captured, 2'b11);
        idle_noise(2);

        // First edge only, pixel 1 misses
        clear_tab();
        pulse_tab[10][0] = 1'b1;
        pulse_tab[11][0] = 1'b1;
        pulse_tab[90][0] = 1'b1;
        run_conv(-1, 0, 1'b0);
        check("first_edge_data", data, 16'hFF0A);
        check("first_edge_cap", captured, 2'b01);

        // Boundary counts, back-to-back start
        clear_tab();
        pulse_tab[0][0]   = 1'b1;
        pulse_tab[255][1] = 1'b1;
        run_conv(-1, 0, 1'b0);
        check("boundary_data", data, 16'hFF00);
        check("boundary_cap", captured, 2'b11);

        // Backpressure with ignored start/enable in HOLD
        clear_tab();
        pulse_tab[37][0]  = 1'b1;
        pulse_tab[200][1] = 1'b1;
        run_conv(-1, 20, 1'b0);
        check("backpressure_data", data, 16'hC825);
        check("backpressure_cap", captured, 2'b11);

        // Reset mid-ramp with pixel 0 already captured
        clear_tab();
        pulse_tab[5][0] = 1'b1;
        run_conv(100, 0, 1'b0);
        check("midreset_outputs", {ramp_count, data, captured, valid, busy, ramp_active}, 0);
        clear_tab();
        pulse_tab[37][0]  = 1'b1;
        pulse_tab[200][1] = 1'b1;
        run_conv(-1, 0, 1'b0);
        check("post_reset_data", data, 16'hC825);

        // Randomized conversions
        for (int r = 0; r < 10; r++) begin
            clear_tab();
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    idx = $urandom_range(0, STEPS);
                    pulse_tab[idx][p] = 1'b1;
                end
            end
            run_conv(-1, $urandom_range(0, 4), 1'b1);
            idle_noise($urandom_range(0, 3));
        end

        tick();
        check("sb_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ramp_capture.md
# ramp_capture

Single-slope ADC conversion controller and per-pixel code capture. It runs the ramp counter for one conversion and consumes the per-pixel rising-edge `enable` pulses from the comparator edge-detection stage. On the first pulse of each pixel it latches the current ramp count as that pixel's digital code. When the ramp ends, it presents all codes to readout through a valid/ready handshake.

## Interface
- `NUM_PIXELS`, default 1: number of comparator/pixel channels; must match the edge-detection stage.
- `COUNT_WIDTH`, default 8: width of the ramp counter and of each pixel code.
- `RAMP_STEPS`, default 255: final ramp count. Legal range is 1 to 2^COUNT_WIDTH−1.
- `clk`, input, 1: rising-edge clock. There is one clock.
- `reset`, input, 1: reset is synchronous and active-high.
- `start`, input, 1: conversion request. Sampled only in IDLE.
- `enable`, input, NUM_PIXELS: per-pixel rising-edge pulses from the edge detection stage.
- `ramp_count`, output, COUNT_WIDTH: current ramp code, driven to the DAC/ramp generator.
- `ramp_active`, output, 1: high while in RAMP.
- `busy`, output, 1: high in RAMP and HOLD.
- `data`, output, NUM_PIXELS*COUNT_WIDTH: pixel codes. Pixel i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- `captured`, output, NUM_PIXELS: bit i is high if pixel i fired during the current or last conversion.
- `valid`, output, 1: the codes are ready for readout.
- `ready`, input, 1: readout accepts the codes.

## Operation
- The FSM has three states: IDLE, RAMP and HOLD. It is fully registered.
- IDLE: if `start`=1, go to RAMP, clear `ramp_count` to 0, clear `captured` to all-zero and clear `data` to 0. Otherwise stay in IDLE.
- RAMP, every cycle:
  - For each pixel i with `enable[i]`=1 and `captured[i]`=0: set `data[i]` to the current `ramp_count` and set `captured[i]` to 1.
  - Later pulses on an already-captured pixel are ignored (first edge wins).
  - If `ramp_count`==RAMP_STEPS, go to HOLD. Otherwise increment `ramp_count` by 1.
- Entering HOLD: every pixel with `captured[i]`=0 gets `data[i]`=RAMP_STEPS (saturated code) and keeps `captured[i]`=0. `ramp_count` holds at RAMP_STEPS.
- HOLD: `valid`=1. When `valid`&&`ready`, go to IDLE. `data` and `captured` keep their values until the next `start` is accepted.
- Ignored inputs:
  - `start` in RAMP or HOLD.
  - `enable` in IDLE or HOLD.
- Arithmetic: the counter never wraps because it stops at RAMP_STEPS. There are no signed quantities.
- Reset, including mid-conversion: state goes to IDLE. All of the following clear to 0: `ramp_count`, `data`, `captured`, `valid`, `ramp_active`, `busy`. No partial results survive.

## Timing
- Start timing: `start` sampled high at edge k puts the block in RAMP after edge k, with `ramp_count`=0 in cycle k+1.
- Counting: `ramp_count`=c in cycle k+1+c, for c from 0 to RAMP_STEPS.
- RAMP length: RAMP lasts RAMP_STEPS+1 cycles.
- Capture latency: `enable[i]` high in the cycle where `ramp_count`=c makes `data[i]`=c and `captured[i]`=1 visible after the next edge.
- Final count: a pulse in the final RAMP cycle (`ramp_count`=RAMP_STEPS) is captured with code RAMP_STEPS and `captured`=1.
- Valid timing: `valid` rises on the first HOLD cycle, which is cycle k+2+RAMP_STEPS.
- Readout: with `ready` held high, the transfer completes in that cycle and `valid` falls the next cycle.
- Back-to-back conversions: the earliest next `start` is accepted in the first IDLE cycle after the handshake.
- Output decode: `ramp_active`, `busy` and `valid` are decoded from the state register only, so they are glitch-free and have no combinational path from the inputs.

## Configuration
- `RAMP_GRAY_EN` defined:
  - The `ramp_count` port carries the Gray code of the internal binary counter. The port is registered, so there is no extra latency.
  - This is for distribution to in-pixel latches.
  - `data` always holds binary codes.
- `RAMP_GRAY_EN` undefined: `ramp_count` is plain binary.

## Test plan
All scenarios use NUM_PIXELS=2, COUNT_WIDTH=8, RAMP_STEPS=255.
- Basic capture: `start` pulse, `enable[0]` at count 37, `enable[1]` at count 200, `ready`=1. Expect `data[0]`=37, `data[1]`=200, `captured`=2'b11, and `valid` one cycle in the 258th cycle after start.
- First-edge-only and miss: `enable[0]` at counts 10, 11 and 90, `enable[1]` never. Expect `data[0]`=10, `data[1]`=255, `captured`=2'b01.
- Boundary counts: `enable[0]` at count 0, `enable[1]` at count 255. Expect codes 0 and 255, `captured`=2'b11.
- Backpressure and ignored inputs: `ready`=0 for 20 HOLD cycles, with `start` and `enable` pulsed during HOLD.
  - Expect `valid` held, `data` unchanged and no restart.
  - Expect IDLE one cycle after `ready`=1.
- Reset mid-RAMP at count 100, with `captured[0]` already set. Expect all outputs 0 the next cycle, then a clean full conversion on the next `start`.
- `RAMP_GRAY_EN` build: check that `ramp_count` equals bin^(bin>>1) each cycle, e.g. 8'h80 at binary 255, and that `data` stays binary.
